// File: rtl/id_stage.sv
// id_stage: two-entry skid-buffered decode stage feeding the immediate generator.
// Define ID_STAGE_ILLEGAL_CHECK_EN to enable out_illegal; otherwise out_illegal is tied to 0.
module id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [2:0]  out_imm_type,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    logic        main_valid_q, main_valid_d;
    logic [31:0] main_instr_q, main_instr_d;
    logic [31:0] main_pc_q,    main_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q,    skid_pc_d;

    logic        accept;
    logic        drain;
    logic [2:0]  imm_type;

    // in_ready comes straight from a flop, so there is no path from out_ready.
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & ~skid_valid_q;
    assign drain    = main_valid_q & out_ready;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        main_valid_d = main_valid_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_instr_d = skid_instr_q;
                main_pc_d    = skid_pc_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_instr_d = in_instr;
                main_pc_d    = in_pc;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_valid_d = 1'b1;
                skid_instr_d = in_instr;
                skid_pc_d    = in_pc;
            end else begin
                main_valid_d = 1'b1;
                main_instr_d = in_instr;
                main_pc_d    = in_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            main_valid_q <= main_valid_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    always_comb begin
        imm_type = 3'b111;
        case (main_instr_q[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: imm_type = 3'b000;
            7'b0100011:                                     imm_type = 3'b001;
            7'b1100011:                                     imm_type = 3'b010;
            7'b0110111, 7'b0010111:                         imm_type = 3'b011;
            7'b1101111:                                     imm_type = 3'b100;
            7'b0110011:                                     imm_type = 3'b101;
            default:                                        imm_type = 3'b111;
        endcase
    end

    assign out_valid    = main_valid_q;
    assign out_instr    = main_valid_q ? main_instr_q : NOP_INSTR;
    assign out_pc       = main_valid_q ? main_pc_q : 32'h0;
    assign out_imm_type = main_valid_q ? imm_type : 3'b000;
    assign out_rs1      = out_instr[19:15];
    assign out_rs2      = out_instr[24:20];
    assign out_rd       = out_instr[11:7];

`ifdef ID_STAGE_ILLEGAL_CHECK_EN
    assign out_illegal = main_valid_q & ((imm_type == 3'b111) | (main_instr_q[1:0] != 2'b11));
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a queue holds every accepted word and
// the DUT outputs are compared against the queue head on every cycle.
module tb_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  t;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  out_imm_type;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_illegal;

    logic [2:0]  cur_type;
    item_t       q[$];
    logic [2:0]  drained[$];
    int          errors = 0;
    int          checks = 0;

    logic [6:0]  ops[10] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b1101111, 7'b0110011, 7'b0001011};
    logic [2:0]  typs[10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001,
                              3'b010, 3'b011, 3'b100, 3'b101, 3'b111};

    id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_imm_type (out_imm_type),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_illegal(input item_t e, input logic v);
`ifdef ID_STAGE_ILLEGAL_CHECK_EN
        return v && ((e.t == 3'b111) || (e.instr[1:0] != 2'b11));
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_state();
        item_t e;
        logic  v;
        v = (q.size() > 0);
        e = v ? q[0] : '{instr: NOP, pc: 32'h0, t: 3'b000};
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_instr", out_instr, e.instr);
        chk("out_pc", out_pc, e.pc);
        chk("out_imm_type", 32'(out_imm_type), 32'(e.t));
        chk("out_rs1", 32'(out_rs1), 32'(e.instr[19:15]));
        chk("out_rs2", 32'(out_rs2), 32'(e.instr[24:20]));
        chk("out_rd", 32'(out_rd), 32'(e.instr[11:7]));
        chk("out_illegal", 32'(out_illegal), 32'(exp_illegal(e, v)));
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [2:0] t, input logic ordy);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        cur_type  = t;
        out_ready = ordy;
    endtask

    // Compare current outputs, advance the model by this cycle's handshakes, then step one clock.
    task automatic tick();
        item_t it;
        logic  acc;
        logic  drn;
        check_state();
        acc = in_valid && (q.size() < 2);
        drn = out_ready && (q.size() > 0);
        if (flush) begin
            q.delete();
        end else begin
            if (drn) begin
                drained.push_back(out_imm_type);
                void'(q.pop_front());
            end
            if (acc) begin
                it = '{instr: in_instr, pc: in_pc, t: cur_type};
                q.push_back(it);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        int          k;

        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
        @(negedge clk);
        check_state();
        rst = 1'b0;

        // Single transfer with one-cycle latency.
        drive(1'b1, 32'h0050_0093, 32'h100, 3'b000, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
        chk("single_rd", 32'(out_rd), 32'd1);
        chk("single_rs1", 32'(out_rs1), 32'd0);
        out_ready = 1'b1;
        tick();
        tick();

        // Backpressure: B and S fill both entries, J waits until space frees up.
        drained.delete();
        drive(1'b1, 32'h0000_0463, 32'h200, 3'b010, 1'b0);
        tick();
        drive(1'b1, 32'h0011_2023, 32'h204, 3'b001, 1'b0);
        tick();
        drive(1'b1, 32'h0000_006F, 32'h208, 3'b100, 1'b0);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        tick();
        tick();
        chk("bp_drain_count", 32'(drained.size()), 32'd3);
        if (drained.size() == 3) begin
            chk("bp_order0", 32'(drained[0]), 32'(3'b010));
            chk("bp_order1", 32'(drained[1]), 32'(3'b001));
            chk("bp_order2", 32'(drained[2]), 32'(3'b100));
        end

        // Flush with both entries full and a word presented: nothing survives.
        drive(1'b1, 32'h0000_0463, 32'h300, 3'b010, 1'b0);
        tick();
        drive(1'b1, 32'h0011_2023, 32'h304, 3'b001, 1'b0);
        tick();
        drive(1'b1, 32'h0000_006F, 32'h308, 3'b100, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        tick();
        tick();

        // Asynchronous reset mid-cycle with the skid entry full.
        drive(1'b1, 32'h0000_0463, 32'h400, 3'b010, 1'b0);
        tick();
        drive(1'b1, 32'h0011_2023, 32'h404, 3'b001, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        check_state();
        @(posedge clk);
        @(negedge clk);
        check_state();
        rst = 1'b0;
        drive(1'b1, 32'h0050_0093, 32'h500, 3'b000, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        tick();

        // Unsupported encoding.
        drive(1'b1, 32'hFFFF_FFFF, 32'h600, 3'b111, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
        chk("illegal_type", 32'(out_imm_type), 32'(3'b111));
`ifdef ID_STAGE_ILLEGAL_CHECK_EN
        chk("illegal_flag", 32'(out_illegal), 32'd1);
`else
        chk("illegal_flag", 32'(out_illegal), 32'd0);
`endif
        out_ready = 1'b1;
        tick();

        // Random valid/ready traffic.
        for (int i = 0; i < 10000; i++) begin
            r = $urandom();
            k = $urandom_range(0, 9);
            drive(1'($urandom_range(0, 1)), {r[31:7], ops[k]}, 32'h1000 + 32'(i) * 4,
                  typs[k], 1'($urandom_range(0, 1)));
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        tick();
        tick();
        tick();
        chk("final_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0013, the instruction word presented on out_instr while the stage holds no valid instruction.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous discard of all held instructions.
REQ-005 SHALL have port in_valid  input  1  fetch presents an instruction.
REQ-006 SHALL have port in_ready  output  1  stage accepts this cycle; registered, not combinational from out_ready.
REQ-007 SHALL have port in_instr  input  32  fetched instruction word.
REQ-008 SHALL have port in_pc  input  32  PC of in_instr.
REQ-009 SHALL have port out_valid  output  1  decoded instruction available downstream.
REQ-010 SHALL have port out_ready  input  1  downstream (immediate generator/execute) accepts.
REQ-011 SHALL have port out_instr  output  32  held instruction word, fed unchanged to the immediate generator instr input.
REQ-012 SHALL have port out_pc  output  32  PC of out_instr.
REQ-013 SHALL have port out_imm_type  output  3  immediate format code for the immediate generator type input.
REQ-014 SHALL have ports out_rs1, out_rs2, out_rd  output  5 each  instr[19:15], instr[24:20], instr[11:7] of out_instr.
REQ-015 SHALL have port out_illegal  output  1  unsupported-encoding flag (see Configuration).

Function
REQ-016 SHALL accept an instruction on a cycle where in_valid and in_ready are both 1, and transfer downstream on a cycle where out_valid and out_ready are both 1.
REQ-017 SHALL be a two-entry skid buffer: main register drives outputs; skid register captures an accepted word when main is valid and not being drained.
REQ-018 SHALL drive in_ready = 1 exactly when the skid register is empty; on the cycle after the skid fills, in_ready = 0.
REQ-019 SHALL give 1-cycle latency: a word accepted with both entries empty appears on out_* the next cycle.
REQ-020 SHALL, on a drain with skid valid, move skid into main the same edge and clear skid; simultaneous accept and drain with skid empty SHALL load main directly.
REQ-021 SHALL preserve strict FIFO order; no word dropped or duplicated under any in_valid/out_ready pattern.
REQ-022 SHALL hold all out_* stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL decode out_imm_type from stored instr[6:0] combinationally off the main register: 0010011, 0000011, 1100111, 1110011 -> 3'b000 (I); 0100011 -> 3'b001 (S); 1100011 -> 3'b010 (B); 0110111, 0010111 -> 3'b011 (U); 1101111 -> 3'b100 (J); 0110011 -> 3'b101 (R, no immediate); any other -> 3'b111.
REQ-024 SHALL drive out_instr = NOP_INSTR, out_pc = 0, out_imm_type = 3'b000 while out_valid = 0.
REQ-025 SHALL, on flush = 1, clear both entries at the next edge (out_valid = 0, in_ready = 1); an in_valid word presented that cycle is discarded; flush has priority over accept and drain.

Reset
REQ-026 SHALL, while rst = 1 regardless of clk, force both entries empty: out_valid = 0, in_ready = 1, out_instr = NOP_INSTR, out_pc = 0, out_illegal = 0.
REQ-027 SHALL, on rst asserted mid-transfer, discard held words; first acceptance permitted on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, with macro ID_STAGE_ILLEGAL_CHECK_EN defined, drive out_illegal = 1 when out_valid = 1 and (out_imm_type = 3'b111 or out_instr[1:0] != 2'b11), else 0.
REQ-029 SHALL, with ID_STAGE_ILLEGAL_CHECK_EN undefined, tie out_illegal to 0; port list unchanged.

Verification
REQ-030 SHALL cover single transfer: in_instr 32'h0050_0093, pc 32'h100, out_ready = 1 -> next cycle out_valid = 1, out_imm_type 3'b000, rd 1, rs1 0.
REQ-031 SHALL cover backpressure: out_ready = 0, three back-to-back words 32'h0000_0463, 32'h0011_2023, 32'h0000_006F -> first two held, in_ready = 0 after second; release yields order B(010), S(001), J(100).
REQ-032 SHALL cover flush with both entries full and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, no stale word ever emitted.
REQ-033 SHALL cover async reset asserted mid-cycle with skid full -> outputs reach reset values before the next clk edge.
REQ-034 SHALL cover illegal word 32'hFFFF_FFFF with macro defined -> out_imm_type 3'b111, out_illegal = 1; macro undefined -> out_illegal = 0.
REQ-035 SHALL cover random in_valid/out_ready (10k cycles) -> output stream equals input stream in order, scoreboard-checked.
